// File: rtl/wb_buffer_pkg.sv
// Shared definitions for the write-back buffer: cache geometry, the evicted
// line format, bus command encodings and the line-to-bus-address mapping.
package wb_buffer_pkg;

  localparam int NUM_WAYS     = 4;
  localparam int NUM_SET_BITS = $clog2(32 / NUM_WAYS);
  localparam int NUM_TAG_BITS = 13 - NUM_SET_BITS;
  localparam int KEY_BITS     = NUM_TAG_BITS + NUM_SET_BITS;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  // One line as presented by the victim cache on eviction.
  typedef struct packed {
    logic [63:0]             data;
    logic [NUM_TAG_BITS-1:0] tag;
    logic                    valid;
    logic                    dirty;
  } cache_line_t;

  // Victim cache entry: a line plus the set it came from.
  typedef struct packed {
    cache_line_t             line;
    logic [NUM_SET_BITS-1:0] idx;
  } vic_cache_t;

  // Byte address of a line, given its {tag, idx} key (8-byte lines).
  function automatic logic [63:0] line_addr(input logic [KEY_BITS-1:0] key);
    return {48'b0, key, 3'b000};
  endfunction

endpackage

// File: rtl/wb_buffer_cam.sv
// Content-addressable match: flags every valid entry whose stored tag equals
// the search key. Used for lookups and for coalescing evictions.
module wb_buffer_cam
  import wb_buffer_pkg::*;
#(
  parameter int LENGTH   = 4,
  parameter int TAG_SIZE = KEY_BITS
) (
  input  logic [LENGTH-1:0]               valid,
  input  logic [LENGTH-1:0][TAG_SIZE-1:0] tags,
  input  logic [TAG_SIZE-1:0]             key,
  output logic [LENGTH-1:0]               hits
);

  // Parallel compare of the key against every entry.
  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      hits[i] = valid[i] && (tags[i] == key);
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer: queues dirty evictions in a small circular FIFO, merges
// repeated writes to the same line, answers lookups from the youngest copy
// and issues the head entry as a bus store whenever the arbiter grants.
module wb_buffer
  import wb_buffer_pkg::*;
#(
  parameter int WR_PORTS = 1,
  parameter int WB_DEPTH = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic        [WR_PORTS-1:0]           evict_valid,
  input  cache_line_t [WR_PORTS-1:0]           evict_line,
  input  logic [WR_PORTS-1:0][NUM_SET_BITS-1:0] evict_idx,
  output logic        [$clog2(WB_DEPTH):0]     wb_free,
  input  logic                                 rd_en,
  input  logic        [NUM_TAG_BITS-1:0]       rd_tag,
  input  logic        [NUM_SET_BITS-1:0]       rd_idx,
  output logic                                 rd_hit,
  output logic        [63:0]                   rd_data,
  input  logic                                 mem_grant,
  input  logic        [3:0]                    mem2proc_response,
  output logic        [1:0]                    proc2mem_command,
  output logic        [63:0]                   proc2mem_addr,
  output logic        [63:0]                   proc2mem_data,
  output logic                                 wb_req,
  input  logic                                 drain,
  output logic                                 drain_done
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // Entry storage and queue control.
  logic [WB_DEPTH-1:0][63:0]       ent_data, data_n;
  logic [WB_DEPTH-1:0][KEY_BITS-1:0] ent_key, key_n;
  logic [WB_DEPTH-1:0]             ent_valid, valid_n;
  logic [PW-1:0]                   head, head_n, tail, tail_n;
  logic [CW-1:0]                   count, count_n, push_cnt;
  logic [0:0]                      state, state_n;

  // Per-port enqueue bookkeeping.
  logic [WR_PORTS-1:0]                 enq;
  logic [WR_PORTS-1:0][KEY_BITS-1:0]   port_key;
  logic [WR_PORTS-1:0][WB_DEPTH-1:0]   co_hits;
  logic [WR_PORTS-1:0]                 port_new;
  logic [WR_PORTS-1:0][PW-1:0]         port_slot;
  logic [PW:0]                         pick;
  logic                                merged;
  logic [PW-1:0]                       slot;

  logic                issuing, pop;
  logic [WB_DEPTH-1:0] rd_hits;
  logic [PW:0]         rd_pick;

  // Youngest hit, scanning oldest-to-youngest from the head. Result is
  // {found, pointer}. The head may be excluded while its store is on the bus.
  function automatic logic [PW:0] pick_youngest(input logic [WB_DEPTH-1:0] hits,
                                                input logic [PW-1:0] start,
                                                input logic skip_head);
    logic [PW:0]   result;
    logic [PW-1:0] p;
    result = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      p = start + PW'(k);
      if (hits[p] && !(skip_head && (k == 0))) result = {1'b1, p};
    end
    return result;
  endfunction

  assign issuing = (state == ST_ISSUE) && mem_grant;
  assign pop     = issuing && (mem2proc_response != 4'h0);

  // Only dirty, valid evictions are worth writing back.
  always_comb begin
    for (int p = 0; p < WR_PORTS; p++) begin
      enq[p]      = evict_valid[p] && evict_line[p].valid && evict_line[p].dirty;
      port_key[p] = {evict_line[p].tag, evict_idx[p]};
    end
  end

  wb_buffer_cam #(.LENGTH(WB_DEPTH), .TAG_SIZE(KEY_BITS)) u_rd_cam (
    .valid (ent_valid),
    .tags  (ent_key),
    .key   ({rd_tag, rd_idx}),
    .hits  (rd_hits)
  );

  for (genvar g = 0; g < WR_PORTS; g++) begin : g_co_cam
    wb_buffer_cam #(.LENGTH(WB_DEPTH), .TAG_SIZE(KEY_BITS)) u_co_cam (
      .valid (ent_valid),
      .tags  (ent_key),
      .key   (port_key[g]),
      .hits  (co_hits[g])
    );
  end

  // Next queue contents: pop the head, then apply evictions in port order,
  // merging into a resident (or same-cycle) copy of the line when possible.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves a value unassigned and no latch is inferred.
    data_n    = ent_data;
    key_n     = ent_key;
    valid_n   = ent_valid;
    head_n    = head;
    tail_n    = tail;
    push_cnt  = '0;
    port_new  = '0;
    port_slot = '0;
    pick      = '0;
    merged    = 1'b0;
    slot      = '0;
    if (pop) begin
      valid_n[head] = 1'b0;
      head_n        = head + PW'(1);
    end
    for (int p = 0; p < WR_PORTS; p++) begin
      if (enq[p]) begin
        pick   = pick_youngest(co_hits[p], head, issuing);
        merged = pick[PW];
        slot   = pick[PW-1:0];
        for (int j = 0; j < p; j++) begin
          if (port_new[j] && (port_key[j] == port_key[p])) begin
            merged = 1'b1;
            slot   = port_slot[j];
          end
        end
        if (merged) begin
          data_n[slot] = evict_line[p].data;
        end else begin
          data_n[tail_n]  = evict_line[p].data;
          key_n[tail_n]   = port_key[p];
          valid_n[tail_n] = 1'b1;
          port_new[p]     = 1'b1;
          port_slot[p]    = tail_n;
          tail_n          = tail_n + PW'(1);
          push_cnt        = push_cnt + CW'(1);
        end
      end
    end
    count_n = count - CW'(pop) + push_cnt;
  end

  // FSM: leave IDLE on the same edge that makes the queue non-empty, so the
  // first store can go out the cycle after the enqueue.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (count_n != '0) state_n = ST_ISSUE;
      ST_ISSUE: if (pop && (count_n == '0)) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Control state and the registered free-slot count.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (reset) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      state     <= ST_IDLE;
      wb_free   <= CW'(WB_DEPTH);
    end else begin
      ent_valid <= valid_n;
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      state     <= state_n;
      wb_free   <= CW'(WB_DEPTH) - count_n;
    end
  end

  // Entry payload.
  // NOTE: payload is deliberately not reset; valid bits gate every read, so
  // stale contents are never observable.
  always_ff @(posedge clock) begin
    ent_data <= data_n;
    ent_key  <= key_n;
  end

  // Lookup returns the youngest resident copy of the line.
  always_comb begin
    rd_pick = pick_youngest(rd_hits, head, 1'b0);
    rd_hit  = rd_en && rd_pick[PW];
    rd_data = rd_hit ? ent_data[rd_pick[PW-1:0]] : 64'h0;
  end

  // Bus outputs: the head goes out only while the arbiter grants.
  always_comb begin
    wb_req           = (state == ST_ISSUE);
    proc2mem_command = issuing ? BUS_STORE : BUS_NONE;
    proc2mem_addr    = issuing ? line_addr(ent_key[head]) : 64'h0;
    proc2mem_data    = issuing ? ent_data[head] : 64'h0;
    drain_done       = drain && (count == '0) && (state == ST_IDLE);
  end

endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: a queue-based reference model acts as
// the scoreboard; a monitor compares every DUT output against it each cycle.
module tb_wb_buffer;
  import wb_buffer_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [KEY_BITS-1:0] key;
    logic [63:0]         data;
  } entry_t;

  logic                          clock = 1'b0;
  logic                          reset;
  logic [0:0]                    evict_valid;
  cache_line_t [0:0]             evict_line;
  logic [0:0][NUM_SET_BITS-1:0]  evict_idx;
  logic [$clog2(DEPTH):0]        wb_free;
  logic                          rd_en;
  logic [NUM_TAG_BITS-1:0]       rd_tag;
  logic [NUM_SET_BITS-1:0]       rd_idx;
  logic                          rd_hit;
  logic [63:0]                   rd_data;
  logic                          mem_grant;
  logic [3:0]                    mem2proc_response;
  logic [1:0]                    proc2mem_command;
  logic [63:0]                   proc2mem_addr;
  logic [63:0]                   proc2mem_data;
  logic                          wb_req;
  logic                          drain;
  logic                          drain_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_store_seen = 0;
  bit mon_en = 1'b0;

  entry_t model_q[$];

  wb_buffer #(.WR_PORTS(1), .WB_DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .evict_valid       (evict_valid),
    .evict_line        (evict_line),
    .evict_idx         (evict_idx),
    .wb_free           (wb_free),
    .rd_en             (rd_en),
    .rd_tag            (rd_tag),
    .rd_idx            (rd_idx),
    .rd_hit            (rd_hit),
    .rd_data           (rd_data),
    .mem_grant         (mem_grant),
    .mem2proc_response (mem2proc_response),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .wb_req            (wb_req),
    .drain             (drain),
    .drain_done        (drain_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is an ordered list of {address, data}. A
  // dirty eviction rewrites the youngest copy of its line unless that copy is
  // the head currently offered on the bus; an accepted store removes the head.
  logic                m_busy, m_pop, m_push;
  logic [KEY_BITS-1:0] m_key;
  int                  m_tgt;
  always @(posedge clock) begin
    if (reset) begin
      model_q.delete();
    end else begin
      m_busy = (model_q.size() > 0) && mem_grant;
      m_pop  = m_busy && (mem2proc_response != 4'h0);
      m_push = 1'b0;
      if (evict_valid[0] && evict_line[0].valid && evict_line[0].dirty) begin
        m_key = {evict_line[0].tag, evict_idx[0]};
        m_tgt = -1;
        for (int i = (m_busy ? 1 : 0); i < model_q.size(); i++)
          if (model_q[i].key == m_key) m_tgt = i;
        if (m_tgt >= 0) model_q[m_tgt].data = evict_line[0].data;
        else m_push = 1'b1;
      end
      if (m_pop) model_q.delete(0);
      if (m_push) begin
        model_q.push_back('{key: m_key, data: evict_line[0].data});
        check("upstream_capacity", 64'(model_q.size() <= DEPTH), 64'd1);
      end
    end
  end

  // Monitor: compare every output against the model, away from the edge.
  logic [63:0] e_cmd, e_addr, e_data, e_rdata;
  logic        e_hit;
  always @(negedge clock) begin
    if (mon_en) begin
      if (proc2mem_command == BUS_STORE) n_store_seen++;
      if ((model_q.size() > 0) && mem_grant) begin
        e_cmd  = 64'(BUS_STORE);
        e_addr = {48'b0, model_q[0].key, 3'b000};
        e_data = model_q[0].data;
      end else begin
        e_cmd  = 64'(BUS_NONE);
        e_addr = '0;
        e_data = '0;
      end
      e_hit   = 1'b0;
      e_rdata = '0;
      if (rd_en)
        for (int i = 0; i < model_q.size(); i++)
          if (model_q[i].key == {rd_tag, rd_idx}) begin
            e_hit   = 1'b1;
            e_rdata = model_q[i].data;
          end
      check("mon_cmd",        64'(proc2mem_command), e_cmd);
      check("mon_addr",       proc2mem_addr, e_addr);
      check("mon_data",       proc2mem_data, e_data);
      check("mon_wb_req",     64'(wb_req), 64'(model_q.size() > 0));
      check("mon_wb_free",    64'(wb_free), 64'(DEPTH - model_q.size()));
      check("mon_rd_hit",     64'(rd_hit), 64'(e_hit));
      check("mon_rd_data",    rd_data, e_rdata);
      check("mon_drain_done", 64'(drain_done), 64'(drain && (model_q.size() == 0)));
    end
  end

  task automatic step(input logic ev, input logic vld, input logic dirty,
                      input logic [NUM_TAG_BITS-1:0] tag, input logic [NUM_SET_BITS-1:0] idx,
                      input logic [63:0] data, input logic grant, input logic [3:0] resp);
    @(posedge clock);
    #1;
    evict_valid[0]       = ev;
    evict_line[0].data   = data;
    evict_line[0].tag    = tag;
    evict_line[0].valid  = vld;
    evict_line[0].dirty  = dirty;
    evict_idx[0]         = idx;
    mem_grant            = grant;
    mem2proc_response    = resp;
    @(negedge clock);
  endtask

  task automatic push(input logic [NUM_TAG_BITS-1:0] tag, input logic [NUM_SET_BITS-1:0] idx,
                      input logic [63:0] data, input logic grant, input logic [3:0] resp);
    step(1'b1, 1'b1, 1'b1, tag, idx, data, grant, resp);
  endtask

  task automatic idle(input logic grant, input logic [3:0] resp);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, grant, resp);
  endtask

  // One randomized cycle; evictions are held back when the model is full.
  logic [NUM_TAG_BITS-1:0] tag_pool [3] = '{10'h010, 10'h020, 10'h3FF};
  task automatic step_rand();
    logic g, ev, will_pop;
    logic [3:0] r;
    @(posedge clock);
    #1;
    g  = ($urandom_range(0, 3) != 0);
    r  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    will_pop = (model_q.size() > 0) && g && (r != 4'h0);
    ev = ($urandom_range(0, 1) == 1);
    if ((model_q.size() - int'(will_pop)) >= DEPTH) ev = 1'b0;
    evict_valid[0]      = ev;
    evict_line[0].data  = {$urandom, $urandom};
    evict_line[0].tag   = tag_pool[$urandom_range(0, 2)];
    evict_line[0].valid = ($urandom_range(0, 9) != 0);
    evict_line[0].dirty = ($urandom_range(0, 4) != 0);
    evict_idx[0]        = NUM_SET_BITS'($urandom_range(0, 1));
    mem_grant           = g;
    mem2proc_response   = r;
    rd_en               = ($urandom_range(0, 1) == 1);
    rd_tag              = tag_pool[$urandom_range(0, 2)];
    rd_idx              = NUM_SET_BITS'($urandom_range(0, 1));
    drain               = ($urandom_range(0, 3) == 0);
    @(negedge clock);
  endtask

  int s0;
  initial begin
    reset = 1'b1;
    evict_valid = '0;
    evict_line  = '0;
    evict_idx   = '0;
    rd_en = 1'b1; rd_tag = '0; rd_idx = '0;
    mem_grant = 1'b0; mem2proc_response = 4'h0; drain = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_wb_free",   64'(wb_free), 64'd4);
    check("reset_cmd",       64'(proc2mem_command), 64'(BUS_NONE));
    check("reset_addr",      proc2mem_addr, 64'h0);
    check("reset_data",      proc2mem_data, 64'h0);
    check("reset_wb_req",    64'(wb_req), 64'd0);
    check("reset_rd_hit",    64'(rd_hit), 64'd0);
    check("reset_rd_data",   rd_data, 64'h0);
    check("reset_drain_done", 64'(drain_done), 64'd0);
    mon_en = 1'b1;

    // Idle drain completes immediately.
    drain = 1'b1;
    idle(1'b0, 4'h0);
    check("idle_drain_done", 64'(drain_done), 64'd1);
    drain = 1'b0;

    // Single store, accepted on first grant.
    push(10'h155, 3'd2, 64'hDEAD, 1'b1, 4'd3);
    idle(1'b1, 4'd3);
    check("store_cmd",  64'(proc2mem_command), 64'(BUS_STORE));
    check("store_addr", proc2mem_addr, 64'h5550);
    check("store_data", proc2mem_data, 64'hDEAD);
    idle(1'b0, 4'h0);
    check("store_wb_free", 64'(wb_free), 64'd4);

    // Clean line is dropped.
    step(1'b1, 1'b1, 1'b0, 10'h0AA, 3'd5, 64'h1234, 1'b0, 4'h0);
    idle(1'b0, 4'h0);
    check("clean_wb_free", 64'(wb_free), 64'd4);
    check("clean_wb_req",  64'(wb_req), 64'd0);

    // Three rejected grants then acceptance: four identical stores, one pop.
    s0 = n_store_seen;
    push(10'h0F0, 3'd3, 64'hBEEF, 1'b0, 4'h0);
    repeat (3) idle(1'b1, 4'h0);
    idle(1'b1, 4'd5);
    idle(1'b0, 4'h0);
    check("retry_store_count", 64'(n_store_seen - s0), 64'd4);
    check("retry_wb_free",     64'(wb_free), 64'd4);

    // Coalesce: A, B, A' -> two entries, lookup returns A' data.
    push(10'h111, 3'd1, 64'h1, 1'b0, 4'h0);
    push(10'h0B0, 3'd6, 64'h7, 1'b0, 4'h0);
    push(10'h111, 3'd1, 64'h2, 1'b0, 4'h0);
    rd_en = 1'b1; rd_tag = 10'h111; rd_idx = 3'd1;
    idle(1'b0, 4'h0);
    check("coalesce_wb_free", 64'(wb_free), 64'd2);
    check("coalesce_rd_hit",  64'(rd_hit), 64'd1);
    check("coalesce_rd_data", rd_data, 64'h2);

    // Fill, then pop and push together while full, then drain in order.
    push(10'h033, 3'd0, 64'h33, 1'b0, 4'h0);
    push(10'h044, 3'd4, 64'h44, 1'b0, 4'h0);
    idle(1'b0, 4'h0);
    check("full_wb_free", 64'(wb_free), 64'd0);
    push(10'h055, 3'd7, 64'h55, 1'b1, 4'd1);
    idle(1'b0, 4'h0);
    check("full_swap_wb_free", 64'(wb_free), 64'd0);
    drain = 1'b1;
    repeat (4) idle(1'b1, 4'd2);
    idle(1'b0, 4'h0);
    check("drain_done_after", 64'(drain_done), 64'd1);
    check("drain_wb_free",    64'(wb_free), 64'd4);
    drain = 1'b0;

    // Reset while a store is outstanding discards everything.
    push(10'h066, 3'd1, 64'h66, 1'b0, 4'h0);
    push(10'h077, 3'd2, 64'h77, 1'b0, 4'h0);
    idle(1'b1, 4'h0);
    reset = 1'b1;
    idle(1'b1, 4'h0);
    reset = 1'b0;
    idle(1'b1, 4'd7);
    check("midreset_cmd",     64'(proc2mem_command), 64'(BUS_NONE));
    check("midreset_wb_req",  64'(wb_req), 64'd0);
    check("midreset_wb_free", 64'(wb_free), 64'd4);

    // Randomized traffic with a small address space to force merges.
    repeat (800) step_rand();
    drain = 1'b1;
    rd_en = 1'b0;
    repeat (40) idle(1'b1, 4'd1);
    check("final_drain_done", 64'(drain_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
